// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : constants and FSM state type shared by the ALU blocks     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  // Frame length width; the framer's frame_len port uses the same width
  localparam int ALU_FRAME_LEN_W = 5;

  localparam int SCHED_GAP_DEFAULT     = 2;
  localparam int SCHED_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    RUN        = 3'd3,
    GAP_WAIT   = 3'd4
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_rr_arb.sv
// +--------------------------------------------------------------------+
// | alu_rr_arb : combinational round-robin arbiter                      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan from the pointer upward, wrapping at N; the first set request wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_frame_sched.sv
// +--------------------------------------------------------------------+
// | alu_frame_sched : round-robin frame request scheduler for framer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_frame_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LEN_W   = ALU_FRAME_LEN_W,
  parameter int GAP     = SCHED_GAP_DEFAULT,
  parameter int TIMEOUT = SCHED_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_val,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [LEN_W-1:0]         frame_len,
  output logic                     frame_len_val,
  input  logic                     frame,
  output logic                     done_val,
  output logic [ID_W-1:0]          done_id,
  output logic                     done_err,
  output logic                     busy,
  output logic                     stray_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  sched_state_t         state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [LEN_W-1:0]     flen_q, flen_d;
  logic                 flv_q, flv_d;
  logic                 dval_q, dval_d;
  logic [ID_W-1:0]      did_q, did_d;
  logic                 derr_q, derr_d;
  logic                 busy_q, busy_d;
  logic                 stray_q, stray_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic [LEN_W-1:0]     lens [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign lens[g] = req_len[g*LEN_W +: LEN_W];
  end

  alu_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i (req_val),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    flen_d  = flen_q;
    flv_d   = 1'b0;
    dval_d  = 1'b0;
    did_d   = did_q;
    derr_d  = 1'b0;
    stray_d = stray_q;

    case (state_q)
      IDLE: begin
        if (frame) stray_d = 1'b1;
        if (|arb_gnt) begin
          ack_d   = arb_gnt;
          id_d    = arb_idx;
          len_d   = lens[arb_idx];
          ptr_d   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (frame) stray_d = 1'b1;
        beat_d = '0;
        tmo_d  = '0;
        if (len_q == '0) begin
          // Zero-length requests never reach the framer
          dval_d  = 1'b1;
          derr_d  = 1'b1;
          did_d   = id_q;
          gap_d   = '0;
          state_d = GAP_WAIT;
        end else begin
          flv_d   = 1'b1;
          flen_d  = len_q;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (frame) begin
          beat_d = LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            dval_d  = 1'b1;
            did_d   = id_q;
            gap_d   = '0;
            state_d = GAP_WAIT;
          end else begin
            state_d = RUN;
          end
        end else if (int'(tmo_q) >= TIMEOUT - 1) begin
          dval_d  = 1'b1;
          derr_d  = 1'b1;
          did_d   = id_q;
          gap_d   = '0;
          state_d = GAP_WAIT;
        end else if (tmo_q != {TMO_W{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RUN: begin
        // beat_q < len_q here, so the increment cannot wrap
        if (frame) begin
          beat_d = beat_q + 1'b1;
          if ((beat_q + 1'b1) == len_q) begin
            dval_d  = 1'b1;
            did_d   = id_q;
            gap_d   = '0;
            state_d = GAP_WAIT;
          end
        end
      end
      GAP_WAIT: begin
        if (frame) stray_d = 1'b1;
        if (int'(gap_q) >= GAP - 1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      flen_q  <= '0;
      flv_q   <= 1'b0;
      dval_q  <= 1'b0;
      did_q   <= '0;
      derr_q  <= 1'b0;
      busy_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      flen_q  <= flen_d;
      flv_q   <= flv_d;
      dval_q  <= dval_d;
      did_q   <= did_d;
      derr_q  <= derr_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign req_ack       = ack_q;
  assign frame_len     = flen_q;
  assign frame_len_val = flv_q;
  assign done_val      = dval_q;
  assign done_id       = did_q;
  assign done_err      = derr_q;
  assign busy          = busy_q;
  assign stray_err     = stray_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_frame_sched.sv
// +--------------------------------------------------------------------+
// | tb_alu_frame_sched : directed self-checking bench for the scheduler |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_frame_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LEN_W   = 5;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_val = '0;
  logic [NUM_REQ*LEN_W-1:0] req_len = '0;
  logic [NUM_REQ-1:0]       req_ack;
  logic [LEN_W-1:0]         frame_len;
  logic                     frame_len_val;
  logic                     frame = 1'b0;
  logic                     done_val;
  logic [ID_W-1:0]          done_id;
  logic                     done_err;
  logic                     busy;
  logic                     stray_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_frame_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .LEN_W   (LEN_W),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_val       (req_val),
    .req_len       (req_len),
    .req_ack       (req_ack),
    .frame_len     (frame_len),
    .frame_len_val (frame_len_val),
    .frame         (frame),
    .done_val      (done_val),
    .done_id       (done_id),
    .done_err      (done_err),
    .busy          (busy),
    .stray_err     (stray_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({req_ack, frame_len, frame_len_val, done_val, done_id, done_err, busy, stray_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {req_ack, frame_len, frame_len_val, done_val, done_id, done_err, busy, stray_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    req_val = 4'b0001;
    req_len = {5'd0, 5'd0, 5'd0, 5'd3};
    @(negedge clk);
    total++;
    if (req_ack !== 4'b0001 || busy !== 1'b1 || frame_len_val !== 1'b0) begin
      bad++;
      $display("FAIL single_ack ack=%b busy=%b flv=%b exp ack=0001 busy=1 flv=0", req_ack, busy, frame_len_val);
    end
    req_val = '0;
    @(negedge clk);
    total++;
    if (frame_len_val !== 1'b1 || frame_len !== 5'd3 || req_ack !== 4'b0000) begin
      bad++;
      $display("FAIL single_strobe flv=%b len=%0d ack=%b exp flv=1 len=3 ack=0000", frame_len_val, frame_len, req_ack);
    end
    frame = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done_val !== 1'b0) begin
      bad++;
      $display("FAIL single_early_done got=%b exp=0", done_val);
    end
    @(negedge clk);
    frame = 1'b0;
    total++;
    if (done_val !== 1'b1 || done_id !== 2'd0 || done_err !== 1'b0) begin
      bad++;
      $display("FAIL single_done val=%b id=%0d err=%b exp val=1 id=0 err=0", done_val, done_id, done_err);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done_val !== 1'b0) begin
      bad++;
      $display("FAIL single_gap busy=%b dv=%b exp busy=1 dv=0", busy, done_val);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_gnt [5];
    bit ok;
    int last_strobe;
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    last_strobe = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_val = 4'b1111;
    req_len = {5'd2, 5'd2, 5'd2, 5'd2};
    for (int g = 0; g < 5; g++) begin
      wait_ack(ok);
      total++;
      if (!ok || req_ack !== exp_gnt[g]) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ack, exp_gnt[g]);
      end
      @(negedge clk);
      total++;
      if (frame_len_val !== 1'b1 || frame_len !== 5'd2) begin
        bad++;
        $display("FAIL rr_strobe%0d flv=%b len=%0d exp flv=1 len=2", g, frame_len_val, frame_len);
      end
      if (g > 0) begin
        total++;
        if (cyc - last_strobe != 6) begin
          bad++;
          $display("FAIL rr_spacing%0d got=%0d exp=6", g, cyc - last_strobe);
        end
      end
      last_strobe = cyc;
      frame = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frame = 1'b0;
      if (g == 4) req_val = '0;
      total++;
      if (done_val !== 1'b1 || done_id !== ID_W'(g % 4) || done_err !== 1'b0) begin
        bad++;
        $display("FAIL rr_done%0d val=%b id=%0d err=%b exp val=1 id=%0d err=0", g, done_val, done_id, done_err, g % 4);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_len;
    req_val = 4'b0100;
    req_len = {5'd2, 5'd0, 5'd2, 5'd2};
    @(negedge clk);
    total++;
    if (req_ack !== 4'b0100) begin
      bad++;
      $display("FAIL zero_ack got=%b exp=0100", req_ack);
    end
    req_val = '0;
    @(negedge clk);
    total++;
    if (done_val !== 1'b1 || done_id !== 2'd2 || done_err !== 1'b1 || frame_len_val !== 1'b0) begin
      bad++;
      $display("FAIL zero_done val=%b id=%0d err=%b flv=%b exp val=1 id=2 err=1 flv=0",
               done_val, done_id, done_err, frame_len_val);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_len_val !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle busy=%b flv=%b exp busy=0 flv=0", busy, frame_len_val);
    end
  endtask

  task automatic test_timeout;
    int early;
    bit ok;
    early = 0;
    req_val = 4'b0010;
    req_len = {5'd1, 5'd0, 5'd4, 5'd0};
    @(negedge clk);
    total++;
    if (req_ack !== 4'b0010) begin
      bad++;
      $display("FAIL tmo_ack got=%b exp=0010", req_ack);
    end
    req_val = '0;
    @(negedge clk);
    total++;
    if (frame_len_val !== 1'b1 || frame_len !== 5'd4) begin
      bad++;
      $display("FAIL tmo_strobe flv=%b len=%0d exp flv=1 len=4", frame_len_val, frame_len);
    end
    for (int k = 1; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (done_val !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL tmo_early_done got=%0d cycles exp=0", early);
    end
    @(negedge clk);
    total++;
    if (done_val !== 1'b1 || done_err !== 1'b1 || done_id !== 2'd1) begin
      bad++;
      $display("FAIL tmo_done val=%b err=%b id=%0d exp val=1 err=1 id=1", done_val, done_err, done_id);
    end
    req_val = 4'b1000;
    wait_ack(ok);
    total++;
    if (!ok || req_ack !== 4'b1000) begin
      bad++;
      $display("FAIL tmo_next_ack got=%b exp=1000", req_ack);
    end
    req_val = '0;
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    total++;
    if (done_val !== 1'b1 || done_err !== 1'b0 || done_id !== 2'd3) begin
      bad++;
      $display("FAIL tmo_next_done val=%b err=%b id=%0d exp val=1 err=0 id=3", done_val, done_err, done_id);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stray;
    total++;
    if (stray_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_pre stray=%b busy=%b exp stray=0 busy=0", stray_err, busy);
    end
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    total++;
    if (stray_err !== 1'b1) begin
      bad++;
      $display("FAIL stray_set got=%b exp=1", stray_err);
    end
    repeat (3) @(negedge clk);
    total++;
    if (stray_err !== 1'b1) begin
      bad++;
      $display("FAIL stray_sticky got=%b exp=1", stray_err);
    end
  endtask

  task automatic test_reset_mid_run;
    int dv_seen;
    bit ok;
    dv_seen = 0;
    req_val = 4'b0001;
    req_len = {5'd1, 5'd1, 5'd1, 5'd5};
    @(negedge clk);
    req_val = '0;
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    frame = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ack, frame_len, frame_len_val, done_val, done_id, done_err, busy, stray_err} !== '0) begin
      bad++;
      $display("FAIL rst_run_outputs got=%b exp=0",
               {req_ack, frame_len, frame_len_val, done_val, done_id, done_err, busy, stray_err});
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_val !== 1'b0) dv_seen++;
    end
    total++;
    if (dv_seen != 0) begin
      bad++;
      $display("FAIL rst_run_no_done got=%0d exp=0", dv_seen);
    end
    req_val = 4'b1111;
    req_len = {5'd1, 5'd1, 5'd1, 5'd1};
    wait_ack(ok);
    total++;
    if (!ok || req_ack !== 4'b0001) begin
      bad++;
      $display("FAIL rst_run_ptr got=%b exp=0001", req_ack);
    end
    req_val = '0;
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    total++;
    if (done_val !== 1'b1 || done_id !== 2'd0 || done_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_run_after val=%b id=%0d err=%b exp val=1 id=0 err=0", done_val, done_id, done_err);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_timeout();
    test_stray();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
